// File: rtl/wb_uart_bridge.sv
// UART-to-Wishbone debug initiator: serial 'W'/'R' frames become single
// Wishbone classic cycles, and the outcome is reported back on ser_tx.
module wb_uart_bridge #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int WW           = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(ACK_TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_WDATA, C_BUS, C_RESP} cmd_state_t;

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_valid, rx_ferr;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state: mid-start recheck rejects glitches
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver bit timing, shift register and one-cycle byte/error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || rx_cnt == BIT_LAST ||
          (rx_state == RX_START && rx_cnt == HALF_LAST))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && rx_cnt == BIT_LAST) begin
        rx_valid <= rx_sync;
        rx_ferr  <= !rx_sync;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_ready;

  assign tx_ready = (tx_state == TX_IDLE);

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // Transmitter next state: each symbol lasts exactly one bit period
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_start) tx_next = TX_START;
      TX_START: if (tx_cnt == BIT_LAST) tx_next = TX_DATA;
      TX_DATA:  if (tx_cnt == BIT_LAST && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt == BIT_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Transmitter datapath; ser_tx is registered so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      ser_tx   <= 1'b1;
    end else begin
      if (tx_state == TX_IDLE || tx_cnt == BIT_LAST) tx_cnt <= '0;
      else                                           tx_cnt <= tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          tx_shift <= tx_byte;
          tx_bit   <= '0;
          ser_tx   <= 1'b0;
        end
        TX_START: if (tx_cnt == BIT_LAST) ser_tx <= tx_shift[0];
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
          ser_tx   <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
        end
        default: ser_tx <= 1'b1;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Command parser and bus master
  // ------------------------------------------------------------------
  cmd_state_t    cmd_state, cmd_next;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [WW-1:0] wd_cnt;
  logic [31:0]   resp_data;
  logic [2:0]    resp_left;

  assign busy_o = (cmd_state != C_IDLE);

  // Command state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_state <= C_IDLE;
    else        cmd_state <= cmd_next;
  end

  // Command next state and transmit handshake
  always_comb begin
    cmd_next = cmd_state;
    tx_start = 1'b0;
    tx_byte  = resp_data[31:24];
    case (cmd_state)
      C_IDLE:
        if (rx_valid)
          cmd_next = (rx_shift == CMD_WRITE || rx_shift == CMD_READ) ? C_ADDR : C_RESP;
      C_ADDR:
        if (rx_ferr) cmd_next = C_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) cmd_next = is_write ? C_WDATA : C_BUS;
      C_WDATA:
        if (rx_ferr) cmd_next = C_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) cmd_next = C_BUS;
      C_BUS:
        if (wbm_cyc_o && (wbm_ack_i || wd_cnt == WD_LAST)) cmd_next = C_RESP;
      C_RESP:
        if (resp_left != 3'd0) tx_start = tx_ready;
        else if (tx_ready) cmd_next = C_IDLE;
      default: cmd_next = C_IDLE;
    endcase
  end

  // Frame collection, Wishbone cycle with watchdog, response queueing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      wd_cnt    <= '0;
      resp_data <= '0;
      resp_left <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_stb_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
    end else begin
      case (cmd_state)
        C_IDLE: begin
          byte_cnt <= '0;
          wd_cnt   <= '0;
          if (rx_valid) begin
            is_write <= (rx_shift == CMD_WRITE);
            if (rx_shift != CMD_WRITE && rx_shift != CMD_READ) begin
              resp_data <= {RSP_NAK, 24'h0};
              resp_left <= 3'd1;
            end
          end
        end
        C_ADDR: if (rx_valid) begin
          wbm_adr_o <= {wbm_adr_o[23:0], rx_shift};
          byte_cnt  <= byte_cnt + 1'b1;
        end
        C_WDATA: if (rx_valid) begin
          wbm_dat_o <= {wbm_dat_o[23:0], rx_shift};
          byte_cnt  <= byte_cnt + 1'b1;
        end
        C_BUS: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_we_o  <= is_write;
            wd_cnt    <= '0;
          end else if (wbm_ack_i || wd_cnt == WD_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            if (!wbm_ack_i) begin
              resp_data <= {RSP_ERR, 24'h0};
              resp_left <= 3'd1;
            end else if (is_write) begin
              resp_data <= {RSP_OK, 24'h0};
              resp_left <= 3'd1;
            end else begin
              resp_data <= wbm_dat_i;
              resp_left <= 3'd4;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        C_RESP: if (tx_start) begin
          resp_data <= {resp_data[23:0], 8'h00};
          resp_left <= resp_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Self-checking bench for wb_uart_bridge: serial frames in, Wishbone
// responder model, serial decoder, expectations from a frame-level model.
`timescale 1ns/1ps
module tb_wb_uart_bridge;

  localparam int CLK_FREQ    = 10_400_000;
  localparam int BAUDRATE    = 100_000;
  localparam int ACK_TIMEOUT = 255;
  localparam int CPB         = CLK_FREQ / BAUDRATE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, busy_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_uart_bridge #(
    .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o)
  );

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // Responder: acks after ack_delay waiting cycles, read data valid only on the ack cycle
  int          ack_delay = 0;
  bit          ack_enable = 1'b1;
  logic [31:0] read_data = 32'h0;
  int          ack_wait = 0;
  always @(negedge clk) begin
    if (wbm_ack_i) begin
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
    end else if (wbm_cyc_o && wbm_stb_o && ack_enable) begin
      if (ack_wait == ack_delay) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = read_data;
        ack_wait  = 0;
      end else begin
        ack_wait++;
        wbm_dat_i = $urandom;
      end
    end else begin
      ack_wait  = 0;
      wbm_dat_i = $urandom;
    end
  end

  // Bus monitor: counts cycles, records their length and checks signals hold steady
  int          bus_starts = 0, cur_len = 0, last_len = 0;
  bit          prev_cyc = 1'b0, bus_stable = 1'b1;
  logic [31:0] snap_adr, snap_dat;
  logic        snap_we;
  logic [3:0]  snap_sel;
  always @(negedge clk) begin
    if (wbm_cyc_o && !prev_cyc) begin
      bus_starts++;
      cur_len  = 0;
      snap_adr = wbm_adr_o;
      snap_dat = wbm_dat_o;
      snap_we  = wbm_we_o;
      snap_sel = wbm_sel_o;
    end
    if (wbm_cyc_o) begin
      cur_len++;
      if (wbm_adr_o !== snap_adr || wbm_dat_o !== snap_dat || wbm_we_o !== snap_we ||
          wbm_sel_o !== snap_sel || wbm_stb_o !== 1'b1)
        bus_stable = 1'b0;
    end
    if (!wbm_cyc_o && prev_cyc) last_len = cur_len;
    prev_cyc = wbm_cyc_o;
  end

  // Serial decoder: captures whole frames and checks every bit spans exactly CPB cycles
  logic [7:0] rx_q[$];
  bit         txok_q[$];
  logic       line_samples [10*CPB];
  initial begin
    forever begin
      @(negedge clk);
      if (ser_tx === 1'b0) begin
        logic [7:0] b;
        bit ok;
        line_samples[0] = ser_tx;
        for (int k = 1; k < 10*CPB; k++) begin
          @(negedge clk);
          line_samples[k] = ser_tx;
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < CPB; j++)
            if (line_samples[i*CPB+j] !== line_samples[i*CPB]) ok = 1'b0;
        if (line_samples[0] !== 1'b0 || line_samples[9*CPB] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = line_samples[(i+1)*CPB + CPB/2];
        rx_q.push_back(b);
        txok_q.push_back(ok);
      end
    end
  end

  // Drives one 8N1 byte onto ser_rx, optionally with a broken stop bit
  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  // Sends a frame and checks the bus cycle and the reply against the frame-level model
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] adr,
                               input logic [31:0] data, input int delay, input bit ack_on);
    logic [7:0] frame[$];
    logic [7:0] expect_q[$];
    int  starts0, budget;
    bit  is_cmd, success, all_ok;
    ack_delay  = delay;
    ack_enable = ack_on;
    read_data  = data;
    bus_stable = 1'b1;
    is_cmd  = (cmd == 8'h57) || (cmd == 8'h52);
    success = ack_on && (delay < ACK_TIMEOUT);
    frame.push_back(cmd);
    if (is_cmd) for (int i = 3; i >= 0; i--) frame.push_back(adr[8*i +: 8]);
    if (cmd == 8'h57) for (int i = 3; i >= 0; i--) frame.push_back(data[8*i +: 8]);
    if (!is_cmd)          expect_q.push_back(8'h15);
    else if (!success)    expect_q.push_back(8'hEE);
    else if (cmd == 8'h57) expect_q.push_back(8'h4B);
    else for (int i = 3; i >= 0; i--) expect_q.push_back(data[8*i +: 8]);

    starts0 = bus_starts;
    rx_q.delete();
    txok_q.delete();
    foreach (frame[i]) sendByte(frame[i], 1'b0);

    budget = expect_q.size() * 11 * CPB + ACK_TIMEOUT + 4 * CPB;
    while (rx_q.size() < expect_q.size() && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkOutput("busy_before_stop_end", 32'(busy_o), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("busy_after_stop_end", 32'(busy_o), 32'd0);
    checkOutput("resp_len", 32'(rx_q.size()), 32'(expect_q.size()));
    for (int i = 0; i < expect_q.size(); i++)
      checkOutput($sformatf("resp_byte%0d", i),
                  (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hx, {24'h0, expect_q[i]});
    all_ok = 1'b1;
    foreach (txok_q[i]) if (!txok_q[i]) all_ok = 1'b0;
    checkOutput("tx_bit_timing", 32'(all_ok), 32'd1);
    checkOutput("bus_cycles", 32'(bus_starts - starts0), is_cmd ? 32'd1 : 32'd0);
    if (is_cmd) begin
      checkOutput("bus_adr", snap_adr, adr);
      checkOutput("bus_we", 32'(snap_we), (cmd == 8'h57) ? 32'd1 : 32'd0);
      checkOutput("bus_sel", 32'(snap_sel), 32'hF);
      checkOutput("bus_stable", 32'(bus_stable), 32'd1);
      checkOutput("bus_len", 32'(last_len), success ? 32'(delay + 1) : 32'(ACK_TIMEOUT));
      if (cmd == 8'h57) checkOutput("bus_dat", snap_dat, data);
    end
  endtask

  // Absolute time limit so the run always ends
  initial begin
    #1_500_000;
    $display("[TB] FAIL global_timeout: simulation time limit reached, wanted completion");
    $fatal(1, "[TB] time limit");
  end

  // Main sequence
  initial begin
    int starts0, budget;
    logic [31:0] a, d;

    repeat (5) @(negedge clk);
    checkOutput("rst_ser_tx", 32'(ser_tx), 32'd1);
    checkOutput("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wbm_stb_o), 32'd0);
    checkOutput("rst_we", 32'(wbm_we_o), 32'd0);
    checkOutput("rst_sel", 32'(wbm_sel_o), 32'd0);
    checkOutput("rst_adr", wbm_adr_o, 32'd0);
    checkOutput("rst_dat", wbm_dat_o, 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] write, read, timeout, ack at expiry, bad command");
    applyStimulus(8'h57, 32'h0008_0000, 32'hDEAD_BEEF, 3, 1'b1);
    applyStimulus(8'h52, 32'h0008_0000, 32'h1234_5678, 3, 1'b1);
    applyStimulus(8'h52, 32'h0000_E000, $urandom, 0, 1'b0);
    applyStimulus(8'h52, $urandom, $urandom, ACK_TIMEOUT - 1, 1'b1);
    applyStimulus(8'h41, 32'h0, 32'h0, 0, 1'b1);

    $display("[TB] 50-cycle glitch on ser_rx");
    rx_q.delete();
    starts0 = bus_starts;
    ser_rx = 1'b0;
    repeat (50) @(negedge clk);
    ser_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("glitch_resp", 32'(rx_q.size()), 32'd0);
    checkOutput("glitch_busy", 32'(busy_o), 32'd0);
    checkOutput("glitch_bus", 32'(bus_starts - starts0), 32'd0);

    $display("[TB] framing error mid-address");
    sendByte(8'h57, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'($urandom), 1'b1);
    repeat (CPB) @(negedge clk);
    checkOutput("ferr_idle", 32'(busy_o), 32'd0);
    applyStimulus(8'h57, $urandom, $urandom, $urandom_range(0, 8), 1'b1);

    $display("[TB] reset during a bus cycle");
    ack_enable = 1'b0;
    a = $urandom;
    d = $urandom;
    sendByte(8'h57, 1'b0);
    for (int i = 3; i >= 0; i--) sendByte(a[8*i +: 8], 1'b0);
    for (int i = 3; i >= 0; i--) sendByte(d[8*i +: 8], 1'b0);
    budget = 4 * CPB;
    while (!wbm_cyc_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reset_cyc_seen", 32'(wbm_cyc_o), 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_cyc", 32'(wbm_cyc_o), 32'd0);
    checkOutput("reset_stb", 32'(wbm_stb_o), 32'd0);
    checkOutput("reset_we", 32'(wbm_we_o), 32'd0);
    checkOutput("reset_ser_tx", 32'(ser_tx), 32'd1);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_adr", wbm_adr_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'h57, $urandom, $urandom, $urandom_range(0, 8), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
